// File: rtl/dcache_wr_buffer_pkg.sv
// Shared write-type encodings and line geometry for the dcache, the write buffer and the bridge.
package dcache_wr_buffer_pkg;

  localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
  localparam logic [2:0] WR_TYPE_HALF = 3'b001;
  localparam logic [2:0] WR_TYPE_WORD = 3'b010;
  localparam logic [2:0] WR_TYPE_LINE = 3'b100;

  // A line is 16 bytes, so the line address drops the low 4 address bits.
  localparam int unsigned LINE_OFF_W = 4;

endpackage

// File: rtl/dcache_wr_buffer_fifo.sv
// In-order FIFO: storage, head/tail pointers and occupancy count.
// Besides the head entry, it exposes a per-slot valid bit and the top TAG_W bits of every slot.
// The owner uses these for associative lookups.
module wb_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [WIDTH-1:0]            i_wdata,
  output logic [WIDTH-1:0]            o_head,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic [DEPTH-1:0]            o_valid,
  output logic [DEPTH-1:0][TAG_W-1:0] o_tag
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  // Storage and per-slot valid bits: write at tail on push, release the head slot on pop
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_wdata;
      end
      if (i_pop) begin
        r_valid[r_head] <= 1'b0;
      end
      if (i_push) begin
        r_valid[r_tail] <= 1'b1;
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the count tracks net push/pop
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (i_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry, count and lookup taps
  always_comb begin
    o_head  = r_mem[r_head];
    o_count = r_count;
    o_valid = r_valid;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_tag[i] = r_mem[i][WIDTH-1 -: TAG_W];
    end
  end

endmodule

// File: rtl/dcache_wr_buffer.sv
// Write-back buffer between the dcache and the bridge write port.
// Evictions and uncached stores are queued and drained in order.
// Reads to queued addresses are flagged as hazards.
module dcache_wr_buffer
  import dcache_wr_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              in_wr_req,
  input  logic [2:0]        in_wr_type,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic [3:0]        in_wr_wstrb,
  input  logic [LINE_W-1:0] in_wr_data,
  output logic              in_wr_rdy,
  output logic              wr_req,
  output logic [2:0]        wr_type,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_wstrb,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_rdy,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit,
  output logic              buf_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = 3 + ADDR_W + 4 + LINE_W;
  // Lookup tag = type plus word address; it sits at the top of each entry
  localparam int unsigned TAG_W = 3 + ADDR_W - 2;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic                        w_push;
  logic                        w_pop;
  logic [ENT_W-1:0]            w_head;
  logic [PTR_W:0]              w_count;
  logic [DEPTH-1:0]            w_valid;
  logic [DEPTH-1:0][TAG_W-1:0] w_tag;
  logic                        w_unused;

  assign w_push = in_wr_req & in_wr_rdy;
  assign w_pop  = wr_req & wr_rdy;

  wb_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .i_clk   (aclk),
    .i_rst_n (aresetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_wr_type, in_wr_addr, in_wr_wstrb, in_wr_data}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_tag   (w_tag)
  );

  // Handshake and status decode from the registered count only
  always_comb begin
    in_wr_rdy = (w_count != FULL_CNT);
    wr_req    = (w_count != '0);
    buf_empty = (w_count == '0);
    {wr_type, wr_addr, wr_wstrb, wr_data} = w_head;
  end

  // Hazard check over every valid slot, including a head slot popping this cycle.
  // Line entries compare the line address; all other types compare the word address.
  always_comb begin
    chk_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid[i]) begin
        if (w_tag[i][TAG_W-1 -: 3] == WR_TYPE_LINE) begin
          chk_hit = chk_hit |
            (w_tag[i][ADDR_W-3:LINE_OFF_W-2] == chk_addr[ADDR_W-1:LINE_OFF_W]);
        end else begin
          chk_hit = chk_hit | (w_tag[i][ADDR_W-3:0] == chk_addr[ADDR_W-1:2]);
        end
      end
    end
  end

  // Byte offset within a word never takes part in the overlap check
  assign w_unused = &{1'b0, chk_addr[1:0]};

endmodule

// File: tb/tb_dcache_wr_buffer.sv
// Directed bench for dcache_wr_buffer with hand-computed expected values.
module tb_dcache_wr_buffer;

  logic         aclk;
  logic         aresetn;
  logic         in_wr_req;
  logic [2:0]   in_wr_type;
  logic [31:0]  in_wr_addr;
  logic [3:0]   in_wr_wstrb;
  logic [127:0] in_wr_data;
  logic         in_wr_rdy;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  chk_addr;
  logic         chk_hit;
  logic         buf_empty;

  int n_total;
  int n_bad;

  dcache_wr_buffer #(
    .DEPTH  (2),
    .ADDR_W (32),
    .LINE_W (128)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .in_wr_req   (in_wr_req),
    .in_wr_type  (in_wr_type),
    .in_wr_addr  (in_wr_addr),
    .in_wr_wstrb (in_wr_wstrb),
    .in_wr_data  (in_wr_data),
    .in_wr_rdy   (in_wr_rdy),
    .wr_req      (wr_req),
    .wr_type     (wr_type),
    .wr_addr     (wr_addr),
    .wr_wstrb    (wr_wstrb),
    .wr_data     (wr_data),
    .wr_rdy      (wr_rdy),
    .chk_addr    (chk_addr),
    .chk_hit     (chk_hit),
    .buf_empty   (buf_empty)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_wr(input logic [2:0] t, input logic [31:0] a,
                          input logic [3:0] s, input logic [127:0] d);
    in_wr_req   = 1'b1;
    in_wr_type  = t;
    in_wr_addr  = a;
    in_wr_wstrb = s;
    in_wr_data  = d;
  endtask

  task automatic check_head(input string tag, input logic [2:0] t, input logic [31:0] a,
                            input logic [3:0] s, input logic [127:0] d);
    check_val({tag, ".req"},   {127'd0, wr_req}, 128'd1);
    check_val({tag, ".type"},  {125'd0, wr_type}, {125'd0, t});
    check_val({tag, ".addr"},  {96'd0, wr_addr}, {96'd0, a});
    check_val({tag, ".wstrb"}, {124'd0, wr_wstrb}, {124'd0, s});
    check_val({tag, ".data"},  wr_data, d);
  endtask

  localparam logic [127:0] D_LINE1 = 128'h4444_3333_2222_1111;
  localparam logic [127:0] D_A     = 128'haaaa_0003_aaaa_0002_aaaa_0001_aaaa_0000;
  localparam logic [127:0] D_B     = 128'h0000_0000_0000_0000_0000_0000_dead_beef;
  localparam logic [127:0] D_X     = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

  initial begin
    n_total     = 0;
    n_bad       = 0;
    aresetn     = 1'b0;
    in_wr_req   = 1'b0;
    in_wr_type  = 3'd0;
    in_wr_addr  = 32'd0;
    in_wr_wstrb = 4'd0;
    in_wr_data  = '0;
    wr_rdy      = 1'b0;
    chk_addr    = 32'd0;
    tick();
    tick();
    aresetn = 1'b1;

    // Reset state
    check_val("rst.req",   {127'd0, wr_req}, 128'd0);
    check_val("rst.type",  {125'd0, wr_type}, 128'd0);
    check_val("rst.addr",  {96'd0, wr_addr}, 128'd0);
    check_val("rst.wstrb", {124'd0, wr_wstrb}, 128'd0);
    check_val("rst.data",  wr_data, 128'd0);
    check_val("rst.rdy",   {127'd0, in_wr_rdy}, 128'd1);
    check_val("rst.hit",   {127'd0, chk_hit}, 128'd0);
    check_val("rst.empty", {127'd0, buf_empty}, 128'd1);

    // Single line write, bridge ready; no bypass in the push cycle
    wr_rdy = 1'b1;
    drive_wr(3'b100, 32'h1c00_0040, 4'h0, D_LINE1);
    check_val("line.nobypass", {127'd0, wr_req}, 128'd0);
    tick();
    in_wr_req = 1'b0;
    check_head("line.head", 3'b100, 32'h1c00_0040, 4'h0, D_LINE1);
    tick();
    check_val("line.empty", {127'd0, buf_empty}, 128'd1);
    check_val("line.req0",  {127'd0, wr_req}, 128'd0);

    // Backpressure: fill, hold head stable, refuse a third push, then drain in order
    wr_rdy = 1'b0;
    drive_wr(3'b100, 32'h0000_0100, 4'h0, D_A);
    tick();
    check_val("bp.rdy1", {127'd0, in_wr_rdy}, 128'd1);
    drive_wr(3'b010, 32'h0000_0204, 4'b0011, D_B);
    tick();
    check_val("bp.full", {127'd0, in_wr_rdy}, 128'd0);
    drive_wr(3'b010, 32'h0000_0300, 4'hf, D_X);
    tick();
    in_wr_req = 1'b0;
    check_head("bp.hold1", 3'b100, 32'h0000_0100, 4'h0, D_A);
    tick();
    check_head("bp.hold2", 3'b100, 32'h0000_0100, 4'h0, D_A);
    check_val("bp.full2", {127'd0, in_wr_rdy}, 128'd0);
    wr_rdy = 1'b1;
    tick();
    check_head("bp.second", 3'b010, 32'h0000_0204, 4'b0011, D_B);
    check_val("bp.rdy2", {127'd0, in_wr_rdy}, 128'd1);
    tick();
    check_val("bp.empty", {127'd0, buf_empty}, 128'd1);

    // Simultaneous push and pop with one entry queued
    wr_rdy = 1'b0;
    drive_wr(3'b100, 32'h0000_0400, 4'h0, D_A);
    tick();
    wr_rdy = 1'b1;
    drive_wr(3'b010, 32'h0000_0500, 4'b1111, D_B);
    tick();
    in_wr_req = 1'b0;
    wr_rdy    = 1'b0;
    check_head("sim.head", 3'b010, 32'h0000_0500, 4'b1111, D_B);
    check_val("sim.rdy", {127'd0, in_wr_rdy}, 128'd1);
    wr_rdy = 1'b1;
    tick();
    check_val("sim.empty", {127'd0, buf_empty}, 128'd1);

    // Wrap: five back-to-back pushes drained at full rate
    wr_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_wr(3'b100, 32'h0000_1000 + 32'(k * 16), 4'h0, 128'(k + 32'h100));
      if (k > 0) begin
        check_val("wrap.data", wr_data, 128'(k - 1 + 32'h100));
        check_val("wrap.addr", {96'd0, wr_addr}, 128'(32'h0000_1000 + 32'((k - 1) * 16)));
      end
      tick();
    end
    in_wr_req = 1'b0;
    check_val("wrap.last", wr_data, 128'h104);
    tick();
    check_val("wrap.empty", {127'd0, buf_empty}, 128'd1);

    // Hazard lookups against a queued line and a queued word
    wr_rdy = 1'b0;
    drive_wr(3'b100, 32'h8000_1230, 4'h0, D_A);
    tick();
    drive_wr(3'b010, 32'h8000_0004, 4'hf, D_B);
    tick();
    in_wr_req = 1'b0;
    chk_addr = 32'h8000_123c; #1 check_val("hz.line_in",  {127'd0, chk_hit}, 128'd1);
    chk_addr = 32'h8000_1240; #1 check_val("hz.line_hi",  {127'd0, chk_hit}, 128'd0);
    chk_addr = 32'h8000_122c; #1 check_val("hz.line_lo",  {127'd0, chk_hit}, 128'd0);
    chk_addr = 32'h8000_0006; #1 check_val("hz.word_in",  {127'd0, chk_hit}, 128'd1);
    chk_addr = 32'h8000_0008; #1 check_val("hz.word_out", {127'd0, chk_hit}, 128'd0);

    // Popping entry still counts as a hazard in its pop cycle
    wr_rdy   = 1'b1;
    chk_addr = 32'h8000_1230;
    #1 check_val("hz.popping", {127'd0, chk_hit}, 128'd1);

    // Reset mid-drain discards both entries
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    wr_rdy  = 1'b0;
    check_val("mrst.req",   {127'd0, wr_req}, 128'd0);
    check_val("mrst.rdy",   {127'd0, in_wr_rdy}, 128'd1);
    check_val("mrst.empty", {127'd0, buf_empty}, 128'd1);
    check_val("mrst.addr",  {96'd0, wr_addr}, 128'd0);
    chk_addr = 32'h8000_1230; #1 check_val("mrst.hit_line", {127'd0, chk_hit}, 128'd0);
    chk_addr = 32'h8000_0004; #1 check_val("mrst.hit_word", {127'd0, chk_hit}, 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
